xvid_host_port: RTL and testbench

XVID_HOST_PORT -- requirements
Module: xvid_host_port

---
 rtl/xvid_host_port.sv | 101 ++++++++++
 tb/tb_xvid_host_port.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/xvid_host_port.sv
`timescale 1ns/1ps
// xvid_host_port: asynchronous host byte bus to 16-bit core register port bridge
module xvid_host_port #(
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        reset_n_i,
   input  logic        bus_cs_n_i,
   input  logic        bus_rd_nwr_i,
   input  logic        bus_bytesel_i,
   input  logic [3:0]  bus_reg_num_i,
   input  logic [7:0]  bus_data_i,
   output logic [7:0]  bus_data_o,
   output logic        reg_wr_o,
   output logic        reg_rd_o,
   output logic [3:0]  reg_num_o,
   output logic [15:0] reg_data_o,
   input  logic [15:0] reg_rd_data_i
);
   typedef enum logic [1:0] {IDLE, CAPTURE, RDWAIT, RELEASE} state_t;
   state_t state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [SYNC_STAGES:0] vld_q, vld_d;
   logic prev_q, prev_d;
   logic [7:0] hi_q, hi_d, bus_data_q, bus_data_d;
   logic [15:0] rd_q, rd_d, data_q, data_d;
   logic [3:0] num_q, num_d;
   logic wr_q, wr_d, rds_q, rds_d;
   logic cs_s, fall;
   // vld_q fills with ones after reset so an edge is only seen once prev/current are real samples
   always_comb begin
      cs_s = sync_q[SYNC_STAGES-1];
      sync_d = {sync_q[SYNC_STAGES-2:0], bus_cs_n_i};
      vld_d = {vld_q[SYNC_STAGES-1:0], 1'b1};
      prev_d = cs_s;
      fall = vld_q[SYNC_STAGES] & prev_q & ~cs_s;
   end
   // next-state and datapath: bus fields are only looked at in CAPTURE
   always_comb begin
      state_d = state_q;
      hi_d = hi_q;
      rd_d = rd_q;
      bus_data_d = bus_data_q;
      num_d = num_q;
      data_d = data_q;
      wr_d = 1'b0;
      rds_d = 1'b0;
      unique case (state_q)
         IDLE: state_d = fall ? CAPTURE : IDLE;
         CAPTURE: begin
            state_d = (bus_rd_nwr_i && !bus_bytesel_i) ? RDWAIT : RELEASE;
            bus_data_d = bus_bytesel_i ? rd_q[7:0] : rd_q[15:8];
            hi_d = (!bus_rd_nwr_i && !bus_bytesel_i) ? bus_data_i : hi_q;
            wr_d = !bus_rd_nwr_i && bus_bytesel_i;
            rds_d = bus_rd_nwr_i && !bus_bytesel_i;
            num_d = (wr_d || rds_d) ? bus_reg_num_i : num_q;
            data_d = wr_d ? {hi_q, bus_data_i} : data_q;
         end
         RDWAIT: begin
            state_d = rds_q ? RDWAIT : RELEASE;
            rd_d = rds_q ? rd_q : reg_rd_data_i;
            bus_data_d = rds_q ? bus_data_q : reg_rd_data_i[15:8];
         end
         RELEASE: state_d = cs_s ? IDLE : RELEASE;
         default: state_d = IDLE;
      endcase
   end
   // state register; reset aborts any transaction in flight
   always_ff @(posedge clk or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q <= IDLE;
         sync_q <= '1;
         vld_q <= '0;
         prev_q <= 1'b1;
         hi_q <= '0;
         rd_q <= '0;
         bus_data_q <= '0;
         num_q <= '0;
         data_q <= '0;
         wr_q <= 1'b0;
         rds_q <= 1'b0;
      end else begin
         state_q <= state_d;
         sync_q <= sync_d;
         vld_q <= vld_d;
         prev_q <= prev_d;
         hi_q <= hi_d;
         rd_q <= rd_d;
         bus_data_q <= bus_data_d;
         num_q <= num_d;
         data_q <= data_d;
         wr_q <= wr_d;
         rds_q <= rds_d;
      end
   end
   assign bus_data_o = bus_data_q;
   assign reg_wr_o = wr_q;
   assign reg_rd_o = rds_q;
   assign reg_num_o = num_q;
   assign reg_data_o = data_q;
endmodule

// File: tb/tb_xvid_host_port.sv
`timescale 1ns/1ps
// tb_xvid_host_port: directed and random host cycles against a transaction-level model
module tb_xvid_host_port;
   localparam realtime T = 83.333;
   logic clk = 1'b0, reset_n_i = 1'b0, bus_cs_n_i = 1'b1, bus_rd_nwr_i = 1'b0, bus_bytesel_i = 1'b0;
   logic [3:0] bus_reg_num_i = '0;
   logic [7:0] bus_data_i = '0;
   logic [15:0] reg_rd_data_i = '0;
   logic [7:0] bus_data_o;
   logic reg_wr_o, reg_rd_o;
   logic [3:0] reg_num_o;
   logic [15:0] reg_data_o;
   int checks = 0, failures = 0;
   logic [15:0] mem [16];
   logic [19:0] wr_obs [$];
   logic [3:0] rd_obs [$];
   logic [7:0] hi_m, bus_m;
   logic [15:0] rd_m, data_m;
   logic [3:0] num_m;
   bit held = 1'b0;

   always #10 clk = ~clk;

   xvid_host_port #(.SYNC_STAGES(2)) dut (
      .clk(clk), .reset_n_i(reset_n_i), .bus_cs_n_i(bus_cs_n_i), .bus_rd_nwr_i(bus_rd_nwr_i),
      .bus_bytesel_i(bus_bytesel_i), .bus_reg_num_i(bus_reg_num_i), .bus_data_i(bus_data_i),
      .bus_data_o(bus_data_o), .reg_wr_o(reg_wr_o), .reg_rd_o(reg_rd_o), .reg_num_o(reg_num_o),
      .reg_data_o(reg_data_o), .reg_rd_data_i(reg_rd_data_i)
   );

   task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
      checks++;
      assert (o === e) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
      end
   endtask

   // strobe monitor and core responder: read word valid from the strobe cycle through the next one
   always @(negedge clk) begin
      if (reg_wr_o) wr_obs.push_back({reg_num_o, reg_data_o});
      if (reg_rd_o) rd_obs.push_back(reg_num_o);
      if (reg_wr_o || reg_rd_o) begin
         checks++;
         assert (!(reg_wr_o && reg_rd_o)) else begin
            failures++;
            $error("FAIL strobe_overlap observed=11 expected=not both");
         end
      end
      if (reg_rd_o) begin
         reg_rd_data_i = mem[reg_num_o];
         held = 1'b1;
      end else if (held) held = 1'b0;
      else reg_rd_data_i = 16'($urandom);
   end

   task automatic host(input bit rd, input bit bs, input logic [3:0] num, input logic [7:0] d,
                       input realtime low, input realtime gap);
      bit exp_wr, exp_rd;
      bus_rd_nwr_i = rd;
      bus_bytesel_i = bs;
      bus_reg_num_i = num;
      bus_data_i = d;
      #(T / 4);
      bus_cs_n_i = 1'b0;
      #(low);
      bus_cs_n_i = 1'b1;
      bus_rd_nwr_i = 1'($urandom);
      bus_bytesel_i = 1'($urandom);
      bus_reg_num_i = 4'($urandom);
      bus_data_i = 8'($urandom);
      #(gap);
      exp_wr = !rd && bs;
      exp_rd = rd && !bs;
      if (!rd && !bs) hi_m = d;
      if (exp_wr) begin
         num_m = num;
         data_m = {hi_m, d};
      end
      if (exp_rd) begin
         num_m = num;
         rd_m = mem[num];
      end
      bus_m = bs ? rd_m[7:0] : rd_m[15:8];
      chk("wr_count", 32'(wr_obs.size()), 32'(exp_wr));
      chk("rd_count", 32'(rd_obs.size()), 32'(exp_rd));
      if (wr_obs.size() != 0) chk("wr_word", 32'(wr_obs[0]), 32'({num, hi_m, d}));
      if (rd_obs.size() != 0) chk("rd_num", 32'(rd_obs[0]), 32'(num));
      chk("bus_data", 32'(bus_data_o), 32'(bus_m));
      chk("reg_num", 32'(reg_num_o), 32'(num_m));
      chk("reg_data", 32'(reg_data_o), 32'(data_m));
      wr_obs.delete();
      rd_obs.delete();
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_wr"}, 32'(reg_wr_o), 32'(0));
      chk({tag, "_rd"}, 32'(reg_rd_o), 32'(0));
      chk({tag, "_num"}, 32'(reg_num_o), 32'(0));
      chk({tag, "_data"}, 32'(reg_data_o), 32'(0));
      chk({tag, "_bus"}, 32'(bus_data_o), 32'(0));
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
      mem[9] = 16'h1234;
      hi_m = '0;
      rd_m = '0;
      num_m = '0;
      data_m = '0;
      repeat (3) @(posedge clk);
      #1 chk_zero("reset");
      reset_n_i = 1'b1;
      repeat (5) @(posedge clk);
      host(1'b0, 1'b1, 4'h3, 8'h55, 4 * T, 4 * T);
      host(1'b0, 1'b0, 4'h8, 8'hAB, 4 * T, 4 * T);
      host(1'b0, 1'b1, 4'h8, 8'hCD, 4 * T, 4 * T);
      host(1'b1, 1'b0, 4'h9, 8'h00, 4 * T, 4 * T);
      chk("read_hi", 32'(bus_data_o), 32'h12);
      host(1'b1, 1'b1, 4'h9, 8'h00, 4 * T, 4 * T);
      chk("read_lo", 32'(bus_data_o), 32'h34);
      host(1'b1, 1'b1, 4'h2, 8'h00, 4 * T, 4 * T);
      host(1'b0, 1'b1, 4'h5, 8'h77, 500.0, 4 * T);
      host(1'b0, 1'b1, 4'h6, 8'h88, 4 * T, 4 * T);
      bus_rd_nwr_i = 1'b0;
      bus_bytesel_i = 1'b1;
      bus_reg_num_i = 4'h4;
      bus_data_i = 8'h99;
      @(posedge clk);
      #1 bus_cs_n_i = 1'b0;
      repeat (3) @(posedge clk);
      #5 reset_n_i = 1'b0;
      #3 chk_zero("abort");
      #20 reset_n_i = 1'b1;
      hi_m = '0;
      rd_m = '0;
      num_m = '0;
      data_m = '0;
      repeat (10) @(posedge clk);
      chk("abort_no_wr", 32'(wr_obs.size()), 32'(0));
      chk_zero("held_low");
      bus_cs_n_i = 1'b1;
      #(4 * T);
      chk("abort_no_rd", 32'(rd_obs.size()), 32'(0));
      wr_obs.delete();
      rd_obs.delete();
      host(1'b0, 1'b1, 4'hA, 8'h11, 4 * T, 4 * T);
      for (int i = 0; i < 40; i++)
         host(1'($urandom), 1'($urandom), 4'($urandom), 8'($urandom), 4 * T, 4 * T);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
